// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_DMA = 1'b1;

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module lat_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory between the CPU and a DMA/loader port.
// Each access holds the memory for MEM_LAT cycles, then pulses the winner's ready.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CntW = $clog2(MEM_LAT + 1);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              winner_q, winner_d;
    logic              we_q, we_d;
    logic              first_q, first_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;
    logic              grant;
    logic              cnt_load, cnt_dec, cnt_zero;

    lat_counter #(
        .W (CntW)
    ) u_lat_counter (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .value (CntW'(MEM_LAT - 1)),
        .dec   (cnt_dec),
        .zero  (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        we_d         = we_q;
        first_d      = first_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        grant        = GRANT_CPU;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    // On a tie the port that did not win last time goes next.
                    if (cpu_req && dma_req) grant = ~last_grant_q;
                    else                    grant = cpu_req ? GRANT_CPU : GRANT_DMA;
                    winner_d     = grant;
                    we_d         = (grant == GRANT_CPU) ? cpu_we    : dma_we;
                    addr_d       = (grant == GRANT_CPU) ? cpu_addr  : dma_addr;
                    wdata_d      = (grant == GRANT_CPU) ? cpu_wdata : dma_wdata;
                    last_grant_d = grant;
                    first_d      = 1'b1;
                    cnt_load     = 1'b1;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                first_d = 1'b0;
                cnt_dec = 1'b1;
                if (cnt_zero) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_DMA;
            winner_q     <= GRANT_CPU;
            we_q         <= 1'b0;
            first_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            we_q         <= we_d;
            first_q      <= first_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            if ((state_q == BUSY) && cnt_zero) begin
                if (winner_q == GRANT_CPU) cpu_rdata_q <= mem_rdata;
                else                       dma_rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        mem_we    = (state_q == BUSY) && first_q && we_q;
        mem_addr  = (state_q == BUSY) ? addr_q  : '0;
        mem_wdata = (state_q == BUSY) ? wdata_q : '0;
        cpu_ready = (state_q == DONE) && (winner_q == GRANT_CPU);
        dma_ready = (state_q == DONE) && (winner_q == GRANT_DMA);
        cpu_rdata = cpu_rdata_q;
        dma_rdata = dma_rdata_q;
    end

endmodule
